// File: rtl/lsu_writeback.sv
// ---------------------------------------------------------------------------
// lsu_writeback
//   Load/store unit between execute and the register-file write port. Takes
//   one memory op per request, runs a valid/ready data-bus transaction, aligns
//   and sign/zero-extends load data, and drives a single-cycle register write.
//
//   Optional feature macro: LSU_TIMEOUT_EN
//     defined   -> bus wait is bounded by TIMEOUT_CYCLES. The parameters
//                  TIMEOUT_CYCLES and CNT_W exist only in this build, with
//                  TIMEOUT_CYCLES < 2**CNT_W.
//     undefined -> the unit waits indefinitely for mem_ready_in.
//
//   Ports
//     clkin, nrst_in             clock, async active-low reset
//     req_*                      request channel (valid/ready, op fields)
//     mem_*                      data-bus master (valid/ready, word address)
//     rf_wr_*                    register-file write port (one-cycle enable)
//     done_out / err_out         one-cycle retire / error pulses
// ---------------------------------------------------------------------------
module lsu_writeback
`ifdef LSU_TIMEOUT_EN
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 8
)
`endif
(
  input  logic        clkin,
  input  logic        nrst_in,
  input  logic        req_valid_in,
  output logic        req_ready_out,
  input  logic        req_we_in,
  input  logic [2:0]  req_funct3_in,
  input  logic [31:0] req_addr_in,
  input  logic [31:0] req_wdata_in,
  input  logic [4:0]  req_rd_idx_in,
  output logic        mem_valid_out,
  input  logic        mem_ready_in,
  output logic        mem_we_out,
  output logic [31:0] mem_addr_out,
  output logic [3:0]  mem_wstrb_out,
  output logic [31:0] mem_wdata_out,
  input  logic [31:0] mem_rdata_in,
  output logic        rf_wr_en_out,
  output logic [4:0]  rf_wr_idx_out,
  output logic [31:0] rf_wr_data_out,
  output logic        done_out,
  output logic        err_out
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned RIDXW = 5;
  localparam int unsigned STRBW = XLEN / 8;

  // funct3[1:0] size encoding
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_WB   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              req_ready_q, req_ready_d;
  logic              mem_valid_q, mem_valid_d;
  logic              mem_we_q, mem_we_d;
  logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
  logic [STRBW-1:0]  mem_wstrb_q, mem_wstrb_d;
  logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
  logic              rf_wr_en_q, rf_wr_en_d;
  logic [RIDXW-1:0]  rf_wr_idx_q, rf_wr_idx_d;
  logic [XLEN-1:0]   rf_wr_data_q, rf_wr_data_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  // Latched request fields needed after the bus handshake
  logic [2:0]        funct3_q, funct3_d;
  logic [1:0]        off_q, off_d;
  logic [RIDXW-1:0]  rd_q, rd_d;

  logic              bad_op_c;
  logic [STRBW-1:0]  strb_c;
  logic [XLEN-1:0]   wdata_c;
  logic [7:0]        ld_byte_c;
  logic [15:0]       ld_half_c;
  logic [XLEN-1:0]   ld_data_c;
  logic              timeout_c;

  // Request legality: illegal funct3 or a misaligned half/word access
  always_comb begin
    bad_op_c = 1'b0;
    if (req_we_in) begin
      if (req_funct3_in[2] || (req_funct3_in[1:0] == 2'b11)) bad_op_c = 1'b1;
    end else begin
      if ((req_funct3_in == 3'b011) || (req_funct3_in[2:1] == 2'b11)) bad_op_c = 1'b1;
    end
    if ((req_funct3_in[1:0] == SZ_H) && req_addr_in[0])          bad_op_c = 1'b1;
    if ((req_funct3_in[1:0] == SZ_W) && (req_addr_in[1:0] != 2'b00)) bad_op_c = 1'b1;
  end

  // Store lane strobes and replicated data; loads drive no strobes
  always_comb begin
    strb_c  = '0;
    wdata_c = '0;
    if (req_we_in) begin
      unique case (req_funct3_in[1:0])
        SZ_B: begin
          strb_c  = STRBW'(4'b0001 << req_addr_in[1:0]);
          wdata_c = {4{req_wdata_in[7:0]}};
        end
        SZ_H: begin
          strb_c  = STRBW'(4'b0011 << {req_addr_in[1], 1'b0});
          wdata_c = {2{req_wdata_in[15:0]}};
        end
        default: begin
          strb_c  = '1;
          wdata_c = req_wdata_in;
        end
      endcase
    end
  end

  // Load alignment from the latched byte offset and extension mode
  assign ld_byte_c = mem_rdata_in[{off_q, 3'b000} +: 8];
  assign ld_half_c = mem_rdata_in[{off_q[1], 4'b0000} +: 16];

  always_comb begin
    unique case (funct3_q)
      3'b000:  ld_data_c = {{24{ld_byte_c[7]}}, ld_byte_c};
      3'b100:  ld_data_c = {24'd0, ld_byte_c};
      3'b001:  ld_data_c = {{16{ld_half_c[15]}}, ld_half_c};
      3'b101:  ld_data_c = {16'd0, ld_half_c};
      default: ld_data_c = mem_rdata_in;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  // Waited-cycle counter: zero outside BUS, counts BUS cycles without handshake
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if ((state_q == S_BUS) && !mem_ready_in) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clkin or negedge nrst_in) begin
    if (!nrst_in) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  // Last permitted waiting cycle; a handshake in this cycle still wins
  assign timeout_c = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_c = 1'b0;
`endif

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    mem_valid_d  = mem_valid_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wstrb_d  = mem_wstrb_q;
    mem_wdata_d  = mem_wdata_q;
    rf_wr_en_d   = 1'b0;
    rf_wr_idx_d  = rf_wr_idx_q;
    rf_wr_data_d = rf_wr_data_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    funct3_d     = funct3_q;
    off_d        = off_q;
    rd_d         = rd_q;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid_in && req_ready_q) begin
          if (bad_op_c) begin
            err_d = 1'b1;
          end else begin
            state_d     = S_BUS;
            mem_valid_d = 1'b1;
            mem_we_d    = req_we_in;
            mem_addr_d  = {req_addr_in[31:2], 2'b00};
            mem_wstrb_d = strb_c;
            mem_wdata_d = wdata_c;
            funct3_d    = req_funct3_in;
            off_d       = req_addr_in[1:0];
            rd_d        = req_rd_idx_in;
          end
        end
      end

      S_BUS: begin
        if (mem_ready_in) begin
          mem_valid_d = 1'b0;
          done_d      = 1'b1;
          if (mem_we_q) begin
            state_d = S_IDLE;
          end else begin
            // done_out coincides with the WB-cycle register write
            state_d      = S_WB;
            rf_wr_en_d   = (rd_q != '0);
            rf_wr_idx_d  = rd_q;
            rf_wr_data_d = ld_data_c;
          end
        end else if (timeout_c) begin
          mem_valid_d = 1'b0;
          err_d       = 1'b1;
          state_d     = S_IDLE;
        end
      end

      S_WB: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d     = S_IDLE;
        mem_valid_d = 1'b0;
      end
    endcase

    // Ready only in IDLE, and held low while done_out pulses so the next
    // accept lands in the cycle after retirement
    req_ready_d = (state_d == S_IDLE) && !done_d;
  end

  // State and output registers
  always_ff @(posedge clkin or negedge nrst_in) begin
    if (!nrst_in) begin
      state_q      <= S_IDLE;
      req_ready_q  <= 1'b1;
      mem_valid_q  <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wstrb_q  <= '0;
      mem_wdata_q  <= '0;
      rf_wr_en_q   <= 1'b0;
      rf_wr_idx_q  <= '0;
      rf_wr_data_q <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      funct3_q     <= '0;
      off_q        <= '0;
      rd_q         <= '0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      mem_valid_q  <= mem_valid_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wstrb_q  <= mem_wstrb_d;
      mem_wdata_q  <= mem_wdata_d;
      rf_wr_en_q   <= rf_wr_en_d;
      rf_wr_idx_q  <= rf_wr_idx_d;
      rf_wr_data_q <= rf_wr_data_d;
      done_q       <= done_d;
      err_q        <= err_d;
      funct3_q     <= funct3_d;
      off_q        <= off_d;
      rd_q         <= rd_d;
    end
  end

  assign req_ready_out  = req_ready_q;
  assign mem_valid_out  = mem_valid_q;
  assign mem_we_out     = mem_we_q;
  assign mem_addr_out   = mem_addr_q;
  assign mem_wstrb_out  = mem_wstrb_q;
  assign mem_wdata_out  = mem_wdata_q;
  assign rf_wr_en_out   = rf_wr_en_q;
  assign rf_wr_idx_out  = rf_wr_idx_q;
  assign rf_wr_data_out = rf_wr_data_q;
  assign done_out       = done_q;
  assign err_out        = err_q;

endmodule

// File: tb/tb_lsu_writeback.sv
// ---------------------------------------------------------------------------
// tb_lsu_writeback
//   Scoreboard bench for lsu_writeback. Expected bus requests and retire
//   events are queued when a request is driven; a bus responder and a retire
//   monitor pop and compare them as the design produces them.
// ---------------------------------------------------------------------------
module tb_lsu_writeback;

  logic        clk;
  logic        nrst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        rf_wr_en;
  logic [4:0]  rf_wr_idx;
  logic [31:0] rf_wr_data;
  logic        done;
  logic        err;

  lsu_writeback dut (
    .clkin          (clk),
    .nrst_in        (nrst),
    .req_valid_in   (req_valid),
    .req_ready_out  (req_ready),
    .req_we_in      (req_we),
    .req_funct3_in  (req_funct3),
    .req_addr_in    (req_addr),
    .req_wdata_in   (req_wdata),
    .req_rd_idx_in  (req_rd),
    .mem_valid_out  (mem_valid),
    .mem_ready_in   (mem_ready),
    .mem_we_out     (mem_we),
    .mem_addr_out   (mem_addr),
    .mem_wstrb_out  (mem_wstrb),
    .mem_wdata_out  (mem_wdata),
    .mem_rdata_in   (mem_rdata),
    .rf_wr_en_out   (rf_wr_en),
    .rf_wr_idx_out  (rf_wr_idx),
    .rf_wr_data_out (rf_wr_data),
    .done_out       (done),
    .err_out        (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          wait_n;
  } bus_exp_t;

  typedef struct {
    logic        done;
    logic        err;
    logic        wr_en;
    logic        chk_data;
    logic [4:0]  idx;
    logic [31:0] data;
    int          acc_cyc;
    int          lat;
  } ret_exp_t;

  bus_exp_t bus_q[$];
  ret_exp_t ret_q[$];

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (got === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Reference models, written from the op definitions
  function automatic logic [31:0] load_model(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] rd);
    logic [31:0] s;
    s = rd >> (8 * int'(off));
    case (f3)
      3'b000:  return ((s & 32'hFF) >= 32'h80) ? ((s & 32'hFF) | 32'hFFFF_FF00) : (s & 32'hFF);
      3'b100:  return s & 32'hFF;
      3'b001:  return ((s & 32'hFFFF) >= 32'h8000) ? ((s & 32'hFFFF) | 32'hFFFF_0000) : (s & 32'hFFFF);
      3'b101:  return s & 32'hFFFF;
      default: return rd;
    endcase
  endfunction

  function automatic logic [3:0] strb_model(input logic [2:0] f3, input logic [1:0] off);
    int nb;
    nb = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    return 4'(((1 << nb) - 1) << int'(off));
  endfunction

  function automatic logic [31:0] wdata_model(input logic [2:0] f3, input logic [31:0] d);
    if (f3[1:0] == 2'b00) return (d & 32'hFF) * 32'h0101_0101;
    if (f3[1:0] == 2'b01) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  // Bus responder: compares request fields every BUS cycle, answers after wait_n
  initial begin : responder
    int waited;
    bus_exp_t be;
    waited    = 0;
    mem_ready = 1'b0;
    mem_rdata = 32'd0;
    forever begin
      @(negedge clk);
      if (mem_valid) begin
        check("ready_low_in_bus", 32'(req_ready), 32'd0);
        if (bus_q.size() == 0) begin
          check("bus_unexpected", 32'(mem_valid), 32'd0);
          mem_ready = 1'b0;
        end else begin
          be = bus_q[0];
          check("bus_addr", mem_addr, be.addr);
          check("bus_we", 32'(mem_we), 32'(be.we));
          check("bus_wstrb", 32'(mem_wstrb), 32'(be.strb));
          if (be.we) check("bus_wdata", mem_wdata, be.wdata);
          if (waited >= be.wait_n) begin
            mem_ready = 1'b1;
            mem_rdata = be.rdata;
            void'(bus_q.pop_front());
            waited = 0;
          end else begin
            mem_ready = 1'b0;
            mem_rdata = $urandom;
            waited    = waited + 1;
          end
        end
      end else begin
        mem_ready = 1'b0;
        waited    = 0;
      end
    end
  end

  // Retire monitor: every done/err/rf write must match the queue head
  initial begin : retire_mon
    ret_exp_t re;
    forever begin
      @(negedge clk);
      if (done || err || rf_wr_en) begin
        if (ret_q.size() == 0) begin
          check("retire_unexpected", 32'({done, err, rf_wr_en}), 32'd0);
        end else begin
          re = ret_q.pop_front();
          check("ret_done", 32'(done), 32'(re.done));
          check("ret_err", 32'(err), 32'(re.err));
          check("ret_rf_wr_en", 32'(rf_wr_en), 32'(re.wr_en));
          if (re.chk_data) begin
            check("ret_rf_idx", 32'(rf_wr_idx), 32'(re.idx));
            check("ret_rf_data", rf_wr_data, re.data);
          end
          if (re.lat >= 0) check("ret_latency", 32'(cyc - re.acc_cyc), 32'(re.lat));
        end
      end
    end
  end

  // Drive one request and queue its expectations; lat < 0 skips latency
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [4:0] rd, input logic [31:0] rdata,
                       input int wait_n, input logic expect_err, input int lat);
    int n;
    bus_exp_t be;
    ret_exp_t re;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n = n + 1;
    end
    check("issue_ready", 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    req_rd     = rd;
    re.acc_cyc = cyc;
    re.lat     = lat;
    if (expect_err) begin
      re.done = 1'b0; re.err = 1'b1; re.wr_en = 1'b0; re.chk_data = 1'b0;
      re.idx  = 5'd0; re.data = 32'd0;
    end else begin
      be.we     = we;
      be.addr   = addr & 32'hFFFF_FFFC;
      be.strb   = we ? strb_model(f3, addr[1:0]) : 4'b0000;
      be.wdata  = wdata_model(f3, wd);
      be.rdata  = rdata;
      be.wait_n = wait_n;
      bus_q.push_back(be);
      re.done     = 1'b1;
      re.err      = 1'b0;
      re.wr_en    = !we && (rd != 5'd0);
      re.chk_data = !we;
      re.idx      = rd;
      re.data     = load_model(f3, addr[1:0], rdata);
    end
    ret_q.push_back(re);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (ret_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n = n + 1;
    end
    check("drain_pending", 32'(ret_q.size()), 32'd0);
    ret_q.delete();
  endtask

  initial begin : main
    nrst      = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_funct3 = 3'd0;
    req_addr  = 32'd0;
    req_wdata = 32'd0;
    req_rd    = 5'd0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_mem_valid", 32'(mem_valid), 32'd0);
    check("rst_rf_wr_en", 32'(rf_wr_en), 32'd0);
    check("rst_done_err", 32'({done, err}), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    nrst = 1'b1;

    // Loads: sign/zero extension, lane selection, zero-wait latency
    issue(1'b0, 3'b000, 32'h103, 32'd0, 5'd5,  32'h80FF_1234, 0, 1'b0, 2); drain();
    issue(1'b0, 3'b101, 32'h102, 32'd0, 5'd6,  32'h8765_4321, 0, 1'b0, 2); drain();
    issue(1'b0, 3'b001, 32'h102, 32'd0, 5'd7,  32'h8765_4321, 0, 1'b0, 2); drain();
    issue(1'b0, 3'b100, 32'h101, 32'd0, 5'd8,  32'h0000_F200, 0, 1'b0, 2); drain();
    issue(1'b0, 3'b000, 32'h100, 32'd0, 5'd9,  32'h1234_567F, 0, 1'b0, 2); drain();
    issue(1'b0, 3'b010, 32'h104, 32'd0, 5'd31, 32'hCAFE_F00D, 0, 1'b0, 2); drain();

    // Stores: strobes and lane replication, no register write
    issue(1'b1, 3'b000, 32'h201, 32'h0000_00AB, 5'd3, 32'd0, 0, 1'b0, -1); drain();
    issue(1'b1, 3'b001, 32'h202, 32'h1234_CDEF, 5'd3, 32'd0, 0, 1'b0, -1); drain();
    issue(1'b1, 3'b010, 32'h204, 32'hDEAD_BEEF, 5'd3, 32'd0, 1, 1'b0, -1); drain();

    // Misaligned and illegal ops: error next cycle, no bus activity
    issue(1'b0, 3'b010, 32'h102, 32'd0, 5'd4, 32'd0, 0, 1'b1, 1); drain();
    issue(1'b0, 3'b001, 32'h101, 32'd0, 5'd4, 32'd0, 0, 1'b1, 1); drain();
    issue(1'b1, 3'b011, 32'h100, 32'd0, 5'd4, 32'd0, 0, 1'b1, 1); drain();
    issue(1'b0, 3'b111, 32'h100, 32'd0, 5'd4, 32'd0, 0, 1'b1, 1); drain();

    // Load to x0: done pulses, register write suppressed
    issue(1'b0, 3'b010, 32'h300, 32'd0, 5'd0, 32'h1234_5678, 0, 1'b0, 2); drain();

    // Wait states: request held stable for 5 cycles
    issue(1'b0, 3'b010, 32'h400, 32'd0, 5'd12, 32'h0BAD_CAFE, 5, 1'b0, 7); drain();

    // Back-to-back ops with no gap in stimulus
    issue(1'b1, 3'b010, 32'h500, 32'h5555_AAAA, 5'd1, 32'd0, 0, 1'b0, -1);
    issue(1'b0, 3'b101, 32'h502, 32'd0, 5'd13, 32'hFEDC_BA98, 2, 1'b0, 4);
    issue(1'b0, 3'b000, 32'h501, 32'd0, 5'd14, 32'h0000_9900, 0, 1'b0, 2);
    drain();

`ifdef LSU_TIMEOUT_EN
    // Bus never answers: abort after 16 waited cycles
    issue(1'b0, 3'b010, 32'h600, 32'd0, 5'd15, 32'd0, 100000, 1'b1, 17);
    drain();
    repeat (2) @(negedge clk);
    check("timeout_bus_idle", 32'(mem_valid), 32'd0);
    bus_q.delete();
`endif

    // Reset during BUS: request and any pending write are dropped at once
    issue(1'b0, 3'b010, 32'h700, 32'd0, 5'd16, 32'd0, 100000, 1'b0, -1);
    repeat (3) @(negedge clk);
    check("pre_rst_mem_valid", 32'(mem_valid), 32'd1);
    #2 nrst = 1'b0;
    #1;
    check("mid_rst_mem_valid", 32'(mem_valid), 32'd0);
    check("mid_rst_rf_wr_en", 32'(rf_wr_en), 32'd0);
    check("mid_rst_req_ready", 32'(req_ready), 32'd1);
    bus_q.delete();
    ret_q.delete();
    repeat (2) @(negedge clk);
    nrst = 1'b1;

    // Recovery after reset
    issue(1'b0, 3'b001, 32'h702, 32'd0, 5'd17, 32'h7FFF_0000, 0, 1'b0, 2); drain();
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Global guard so the run always ends
  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
